tinynpu_sched: RTL and testbench

Round-robin job scheduler that shares one TinyNPU datapath/controller pair between `NREQ` host requesters. A granted requester streams one job (`SIZE` input words, then `SIZE*SIZE` weight words); the scheduler steers those words into the x/w FIFO load strobes and pulses `mac_val`. It then routes the `SIZE` result beats back to the owner and signals completion. It sits between the host ports and the NPU controller's `d2c_*_load_*` and `d2c_mac_val` inputs.

---
 rtl/tinynpu_pkg.sv | 25 ++
 rtl/tinynpu_rr_arb.sv | 42 ++++
 rtl/tinynpu_sched.sv | 203 ++++++++++++++++++++
 tb/tb_tinynpu_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinynpu_pkg.sv
// -----------------------------------------------------------------------------
// tinynpu_pkg
// Shared types and default configuration for the TinyNPU job scheduler.
//   sched_state_t : scheduler FSM state encoding
//   SEL_W / OWN_W : select / owner index widths for the default configuration
// -----------------------------------------------------------------------------
package tinynpu_pkg;

    localparam int SIZE_DEF   = 4;
    localparam int DATA_W_DEF = 8;
    localparam int NREQ_DEF   = 2;

    localparam int SEL_W = $clog2(SIZE_DEF);
    localparam int OWN_W = $clog2(NREQ_DEF);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_X = 3'd1,
        ST_LOAD_W = 3'd2,
        ST_MAC    = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5
    } sched_state_t;

endpackage

// File: rtl/tinynpu_rr_arb.sv
// -----------------------------------------------------------------------------
// tinynpu_rr_arb
// Combinational round-robin picker: grants the first asserted request at or
// after ptr_i, wrapping cyclically.
//   req_i : request vector
//   ptr_i : index searched first
//   gnt_o : one-hot grant (all zero when no request)
//   idx_o : index of the granted request
//   any_o : at least one request present
// -----------------------------------------------------------------------------
module tinynpu_rr_arb #(
    parameter int NREQ  = 2,
    parameter int OWN_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [OWN_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [OWN_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int cand;
        cand  = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr_i is always < NREQ, so one subtraction is enough to wrap
            cand = int'(ptr_i) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = OWN_W'(cand);
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tinynpu_sched.sv
// -----------------------------------------------------------------------------
// tinynpu_sched
// Round-robin job scheduler sharing one TinyNPU datapath between NREQ hosts.
// A granted host streams SIZE x words then SIZE*SIZE w words (column-major),
// the scheduler fires one MAC pulse and routes SIZE result beats back.
//
// Ports
//   clk, rst_n                 : clock, async active-low reset
//   req_val_i / req_gnt_o      : per-host level request / 1-cycle one-hot grant
//   in_val_i/in_data_i/in_rdy_o: per-host load stream (owner only is ready)
//   res_val_o / res_data_o     : result beats to owner (combinational)
//   req_done_o                 : 1-cycle job-complete pulse
//   s2d_*_o                    : x/w FIFO load strobes, column select, data, MAC
//   d2s_out_val_i/_data_i      : datapath result beats
//   busy_o, owner_o, err_o     : status; err_o is sticky until reset
//
// state   | meaning
// IDLE    | wait for any request, grant round-robin
// LOAD_X  | accept SIZE x words from owner
// LOAD_W  | accept SIZE*SIZE w words from owner
// MAC     | one-cycle start-MAC pulse
// WAIT    | forward SIZE result beats to owner
// DONE    | completion pulse, advance round-robin pointer
// -----------------------------------------------------------------------------
module tinynpu_sched
    import tinynpu_pkg::*;
#(
    parameter  int SIZE   = SIZE_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NREQ   = NREQ_DEF,
    localparam int SW     = $clog2(SIZE),
    localparam int OW     = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_val_i,
    output logic [NREQ-1:0]        req_gnt_o,
    input  logic [NREQ-1:0]        in_val_i,
    input  logic [NREQ*DATA_W-1:0] in_data_i,
    output logic [NREQ-1:0]        in_rdy_o,
    output logic [NREQ-1:0]        res_val_o,
    output logic [DATA_W-1:0]      res_data_o,
    output logic [NREQ-1:0]        req_done_o,
    output logic                   s2d_x_load_val_o,
    output logic                   s2d_w_load_val_o,
    output logic [SW-1:0]          s2d_w_load_sel_o,
    output logic [DATA_W-1:0]      s2d_load_data_o,
    output logic                   s2d_mac_val_o,
    input  logic                   d2s_out_val_i,
    input  logic [DATA_W-1:0]      d2s_out_data_i,
    output logic                   busy_o,
    output logic [OW-1:0]          owner_o,
    output logic                   err_o
);

    localparam int CNT_W = $clog2(SIZE*SIZE) + 1;
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(SIZE*SIZE - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(SIZE - 1);

    sched_state_t      state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [OW-1:0]     arb_idx;
    logic              arb_any;
    logic [NREQ-1:0]   own_oh;
    logic              own_in_val;
    logic [DATA_W-1:0] own_in_data;
    logic              loading;

    tinynpu_rr_arb #(
        .NREQ  (NREQ),
        .OWN_W (OW)
    ) u_arb (
        .req_i (req_val_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        own_oh          = '0;
        own_oh[owner_q] = 1'b1;
    end

    assign own_in_val  = in_val_i[owner_q];
    assign own_in_data = in_data_i[owner_q*DATA_W +: DATA_W];
    assign loading     = (state_q == ST_LOAD_X) || (state_q == ST_LOAD_W);

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        rr_ptr_d         = rr_ptr_q;
        cnt_d            = cnt_q;
        req_gnt_o        = '0;
        in_rdy_o         = '0;
        res_val_o        = '0;
        res_data_o       = '0;
        req_done_o       = '0;
        s2d_x_load_val_o = 1'b0;
        s2d_w_load_val_o = 1'b0;
        s2d_w_load_sel_o = '0;
        s2d_load_data_o  = '0;
        s2d_mac_val_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (arb_any) begin
                    req_gnt_o = arb_gnt;
                    owner_d   = arb_idx;
                    state_d   = ST_LOAD_X;
                end
            end
            ST_LOAD_X: begin
                in_rdy_o = own_oh;
                if (own_in_val) begin
                    s2d_x_load_val_o = 1'b1;
                    s2d_load_data_o  = own_in_data;
                    if (cnt_q == X_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD_W;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LOAD_W: begin
                in_rdy_o = own_oh;
                if (own_in_val) begin
                    s2d_w_load_val_o = 1'b1;
                    s2d_load_data_o  = own_in_data;
                    // beat / SIZE: column-major fill of the w FIFOs
                    s2d_w_load_sel_o = cnt_q[2*SW-1:SW];
                    if (cnt_q == W_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_MAC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_MAC: begin
                s2d_mac_val_o = 1'b1;
                cnt_d         = '0;
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                if (d2s_out_val_i) begin
                    res_val_o  = own_oh;
                    res_data_o = d2s_out_data_i;
                    if (cnt_q == R_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                req_done_o = own_oh;
                rr_ptr_d   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
                cnt_d      = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stray result beats and writes from non-owners are dropped but flagged
    assign err_d = err_q
                 | (d2s_out_val_i && (state_q != ST_WAIT))
                 | (loading && (|(in_val_i & ~own_oh)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign owner_o = owner_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_tinynpu_sched.sv
// -----------------------------------------------------------------------------
// tb_tinynpu_sched
// Self-checking bench for tinynpu_sched (SIZE=4, DATA_W=8, NREQ=2).
// Jobs are driven from a vector table, then randomized jobs are predicted by a
// round-robin reference model; reset and request-drop corner cases are
// hand-sequenced.
// -----------------------------------------------------------------------------
module tb_tinynpu_sched;

    localparam int SIZE   = 4;
    localparam int DATA_W = 8;
    localparam int NREQ   = 2;
    localparam int SW     = 2;
    localparam int OW     = 1;
    localparam int NW     = SIZE + SIZE*SIZE;
    localparam int TMO    = 200;

    typedef logic [NREQ*DATA_W-1:0] data_vec_t;

    typedef struct {
        logic [NREQ-1:0] req;
        int              gap;
        int              inject;
        logic [NREQ-1:0] exp_gnt;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_val;
    logic [NREQ-1:0]        req_gnt;
    logic [NREQ-1:0]        in_val;
    logic [NREQ*DATA_W-1:0] in_data;
    logic [NREQ-1:0]        in_rdy;
    logic [NREQ-1:0]        res_val;
    logic [DATA_W-1:0]      res_data;
    logic [NREQ-1:0]        req_done;
    logic                   x_val;
    logic                   w_val;
    logic [SW-1:0]          w_sel;
    logic [DATA_W-1:0]      load_data;
    logic                   mac_val;
    logic                   d2s_out_val;
    logic [DATA_W-1:0]      d2s_out_data;
    logic                   busy;
    logic [OW-1:0]          owner;
    logic                   err;

    int   errors = 0;
    int   checks = 0;
    int   rr_m   = 0;
    bit   err_m  = 1'b0;
    vec_t vecs[8];

    tinynpu_sched #(.SIZE(SIZE), .DATA_W(DATA_W), .NREQ(NREQ)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_val_i        (req_val),
        .req_gnt_o        (req_gnt),
        .in_val_i         (in_val),
        .in_data_i        (in_data),
        .in_rdy_o         (in_rdy),
        .res_val_o        (res_val),
        .res_data_o       (res_data),
        .req_done_o       (req_done),
        .s2d_x_load_val_o (x_val),
        .s2d_w_load_val_o (w_val),
        .s2d_w_load_sel_o (w_sel),
        .s2d_load_data_o  (load_data),
        .s2d_mac_val_o    (mac_val),
        .d2s_out_val_i    (d2s_out_val),
        .d2s_out_data_i   (d2s_out_data),
        .busy_o           (busy),
        .owner_o          (owner),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requester at or after ptr, cyclically.
    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return 0;
    endfunction

    task automatic idle_zero(input string tag);
        chk({tag, "_gnt"},   req_gnt,   0);
        chk({tag, "_rdy"},   in_rdy,    0);
        chk({tag, "_res"},   res_val,   0);
        chk({tag, "_rdat"},  res_data,  0);
        chk({tag, "_done"},  req_done,  0);
        chk({tag, "_xval"},  x_val,     0);
        chk({tag, "_wval"},  w_val,     0);
        chk({tag, "_wsel"},  w_sel,     0);
        chk({tag, "_ldat"},  load_data, 0);
        chk({tag, "_mac"},   mac_val,   0);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_owner"}, owner,     0);
        chk({tag, "_err"},   err,       0);
    endtask

    // Runs one job starting in an IDLE cycle. gap: 0 no stalls, 1 every other
    // cycle, 2 random. inject: 1 stray result beat in LOAD_W, 2 non-owner
    // in_val in LOAD_X. abort_at >= 0 asserts reset when that load word is due.
    task automatic run_job(input logic [NREQ-1:0] reqs, input int gap, input int inject,
                           input int abort_at, input logic [NREQ-1:0] exp_gnt, input bit first);
        logic [DATA_W-1:0] words[NW];
        logic [DATA_W-1:0] d;
        int g, other, idx, cyc, nres;
        bit v, injected;
        g = 0;
        for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) g = i;
        other = (g + 1) % NREQ;
        for (int k = 0; k < NW; k++)
            words[k] = first ? DATA_W'((k < SIZE) ? k + 1 : 10 + k - SIZE) : DATA_W'($urandom);

        req_val = reqs;
        #1;
        chk("grant", req_gnt, exp_gnt);
        chk("idle_busy", busy, 0);
        tick();
        chk("owner", owner, g);

        idx = 0; cyc = 0; injected = 1'b0;
        while (idx < NW && cyc < TMO) begin
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            in_val      = '0;
            in_val[g]   = v;
            in_data     = data_vec_t'($urandom);
            if (v) in_data[g*DATA_W +: DATA_W] = words[idx];
            d2s_out_val = 1'b0;
            if (inject == 2 && idx == 1 && !injected) begin
                in_val[other] = 1'b1; injected = 1'b1; err_m = 1'b1;
            end
            if (inject == 1 && idx == SIZE + 2 && !injected) begin
                d2s_out_val = 1'b1; d2s_out_data = DATA_W'($urandom);
                injected = 1'b1; err_m = 1'b1;
            end
            if (idx == abort_at) begin
                req_val = '0; in_val = '0; d2s_out_val = 1'b0;
                rst_n = 1'b0;
                #1;
                idle_zero("abort");
                err_m = 1'b0; rr_m = 0;
                tick(); tick();
                rst_n = 1'b1;
                tick();
                return;
            end
            #1;
            chk("in_rdy", in_rdy, exp_gnt);
            chk("x_strobe", x_val, v && idx < SIZE);
            chk("w_strobe", w_val, v && idx >= SIZE);
            chk("load_data", load_data, v ? words[idx] : 0);
            chk("w_sel", w_sel, (v && idx >= SIZE) ? (idx - SIZE) / SIZE : 0);
            chk("load_res_val", res_val, 0);
            chk("load_mac", mac_val, 0);
            if (v) idx++;
            cyc++;
            tick();
        end
        chk("load_words", idx, NW);

        in_val = '0; d2s_out_val = 1'b0;
        #1;
        chk("mac_pulse", mac_val, 1);
        chk("mac_rdy", in_rdy, 0);
        tick();
        req_val[g] = 1'b0;

        nres = 0; cyc = 0;
        while (nres < SIZE && cyc < TMO) begin
            v = (gap == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            d = DATA_W'($urandom);
            d2s_out_val  = v;
            d2s_out_data = d;
            #1;
            chk("res_val", res_val, v ? exp_gnt : 0);
            chk("res_data", res_data, v ? d : 0);
            chk("mac_once", mac_val, 0);
            chk("early_done", req_done, 0);
            if (v) nres++;
            cyc++;
            tick();
        end
        chk("res_beats", nres, SIZE);

        d2s_out_val = 1'b0;
        #1;
        chk("done", req_done, exp_gnt);
        chk("done_busy", busy, 1);
        rr_m = (g + 1) % NREQ;
        tick();
        chk("idle_after", busy, 0);
        chk("done_once", req_done, 0);
        chk("err", err, err_m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] r, e;
        int p;

        vecs[0] = '{2'b11, 0, 0, 2'b01};
        vecs[1] = '{2'b11, 1, 0, 2'b10};
        vecs[2] = '{2'b11, 2, 0, 2'b01};
        vecs[3] = '{2'b11, 1, 0, 2'b10};
        vecs[4] = '{2'b10, 0, 0, 2'b10};
        vecs[5] = '{2'b01, 2, 0, 2'b01};
        vecs[6] = '{2'b11, 0, 1, 2'b10};
        vecs[7] = '{2'b01, 1, 2, 2'b01};

        rst_n = 1'b0; req_val = '0; in_val = '0; in_data = '0;
        d2s_out_val = 1'b0; d2s_out_data = '0;
        repeat (3) tick();
        idle_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++)
            run_job(vecs[i].req, vecs[i].gap, vecs[i].inject, -1, vecs[i].exp_gnt, i == 0);

        // reset in the middle of LOAD_W, then a clean job from x word 0
        run_job(2'b01, 0, 0, SIZE + 5, 2'b01, 1'b0);
        run_job(2'b01, 0, 0, -1, 2'b01, 1'b1);

        for (int j = 0; j < 10; j++) begin
            r = NREQ'($urandom_range(1, 3));
            p = pick(r, rr_m);
            e = '0;
            e[p] = 1'b1;
            run_job(r, 2, 0, -1, e, 1'b0);
        end

        // owner drops its request in WAIT; requester 1 stays pending
        if (rr_m != 0) run_job(2'b10, 0, 0, -1, 2'b10, 1'b0);
        run_job(2'b11, 2, 0, -1, 2'b01, 1'b0);
        run_job(2'b10, 0, 0, -1, 2'b10, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
